ingress_frame_validator: RTL

- Upstream neighbour of the ingress filter. It sits between the MAC-side 16-bit AXI-stream and the filter's frame and sideband FIFOs.
- Forwards frame half-words through one registered stage with back-pressure.
- Counts frame length and classifies each frame as ok, runt, giant or MAC-error.
- At frame end, emits one 20-bit sideband word. The filter uses this word to commit the frame or to rewind its frame-FIFO write pointer.

---
 rtl/ingress_frame_validator.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ingress_frame_validator.sv
// Ingress frame validator: forwards a 16-bit AXI-stream through one egress register, measures and classifies each frame, and emits a 20-bit sideband word.
// Optional statistics counters are enabled with `define PF_VALIDATOR_STATS_EN.
module ingress_frame_validator #(
    parameter int unsigned MIN_HW = 30,
    parameter int unsigned MAX_HW = 759,
    parameter int unsigned LEN_W  = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [15:0] s_tdata,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] m_tdata,
    output logic        m_tlast,
    output logic        sb_valid,
    input  logic        sb_ready,
    output logic [19:0] sb_data
`ifdef PF_VALIDATOR_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_ok,
    output logic [15:0] stat_bad
`endif
);

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned SB_W     = 20;
    localparam int unsigned SB_LEN_W = 11;

    localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_HW);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_HW);
    localparam logic [LEN_W-1:0] LEN_SAT_L = '1;
    localparam logic [LEN_W-1:0] LEN_ONE_L = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DROP,
        SB
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d, len_inc;
    logic                m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic                m_tlast_q, m_tlast_d;
    logic                sb_valid_q, sb_valid_d;
    logic [SB_W-1:0]     sb_data_q, sb_data_d;
    logic                accept;

    // Sideband word: {giant, runt, err, ok, 5'b0, len}; a saturated length is always giant.
    function automatic logic [SB_W-1:0] sb_word(input logic [LEN_W-1:0] l, input logic err);
        logic runt;
        logic giant;
        logic ok;
        runt  = (l < MIN_L);
        giant = (l > MAX_L) | (l == LEN_SAT_L);
        ok    = ~(runt | giant | err);
        return {giant, runt, err, ok, 5'b0, SB_LEN_W'(l)};
    endfunction

    // Ingress ready: DROP sinks everything, SB stalls, otherwise the egress slot must be free.
    always_comb begin
        s_tready = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE, FRAME: s_tready = ~m_tvalid_q | m_tready;
                DROP:        s_tready = 1'b1;
                default:     s_tready = 1'b0;
            endcase
        end
    end

    assign accept  = s_tvalid & s_tready;
    assign len_inc = (len_q == LEN_SAT_L) ? len_q : LEN_W'(len_q + LEN_ONE_L);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        m_tvalid_d = m_tvalid_q & ~m_tready;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        sb_valid_d = sb_valid_q;
        sb_data_d  = sb_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (en) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = s_tdata;
                        m_tlast_d  = s_tlast;
                        len_d      = LEN_ONE_L;
                        if (s_tlast) begin
                            state_d    = SB;
                            sb_valid_d = 1'b1;
                            sb_data_d  = sb_word(LEN_ONE_L, s_tuser);
                        end else begin
                            state_d = FRAME;
                        end
                    end else if (!s_tlast) begin
                        state_d = DROP;
                    end
                end
            end
            FRAME: begin
                if (accept) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = s_tdata;
                    m_tlast_d  = s_tlast;
                    len_d      = len_inc;
                    if (s_tlast) begin
                        state_d    = SB;
                        sb_valid_d = 1'b1;
                        sb_data_d  = sb_word(len_inc, s_tuser);
                    end
                end
            end
            DROP: begin
                if (accept && s_tlast) begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            end
            SB: begin
                if (sb_ready) begin
                    state_d    = IDLE;
                    sb_valid_d = 1'b0;
                    len_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
                len_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            sb_valid_q <= 1'b0;
            sb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            sb_valid_q <= sb_valid_d;
            sb_data_q  <= sb_data_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;
    assign sb_valid = sb_valid_q;
    assign sb_data  = sb_data_q;

`ifdef PF_VALIDATOR_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic              sb_accept;
    logic [STAT_W-1:0] stat_ok_q, stat_bad_q;

    assign sb_accept = sb_valid_q & sb_ready;

    // Saturating frame counters, bucketed by the ok bit of each accepted sideband word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ok_q  <= '0;
            stat_bad_q <= '0;
        end else if (stat_clr) begin
            stat_ok_q  <= '0;
            stat_bad_q <= '0;
        end else if (sb_accept) begin
            if (sb_data_q[16]) begin
                if (stat_ok_q != '1) stat_ok_q <= STAT_W'(stat_ok_q + STAT_W'(1));
            end else begin
                if (stat_bad_q != '1) stat_bad_q <= STAT_W'(stat_bad_q + STAT_W'(1));
            end
        end
    end

    assign stat_ok  = stat_ok_q;
    assign stat_bad = stat_bad_q;
`endif

endmodule
